mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 47 ++++
 rtl/mem_arb_tag_fifo.sv | 58 +++++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared memory-bundle types for the two-requester memory arbiter.
//   MemoryIn  (70b) : request payload + req_valid        (requester -> memory)
//   MemoryOut (34b) : response data + req_ready + res_valid (memory -> requester)
//   ArbState        : arbiter flush sequencing state
//   MemSource       : tag stored per in-flight request (which port gets the response)
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    M_XRD       = 2'd0,
    M_XWR       = 2'd1,
    M_FLUSH_ALL = 2'd2
  } MemFcn;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    MemFcn       fcn;
    logic [2:0]  typ;
  } MemoryReq;   // 69 bits

  typedef struct packed {
    logic [31:0] data;
  } MemoryRes;   // 32 bits

  typedef struct packed {
    MemoryReq req;
    logic     req_valid;
  } MemoryIn;    // 70 bits

  typedef struct packed {
    MemoryRes res;
    logic     req_ready;
    logic     res_valid;
  } MemoryOut;   // 34 bits

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } ArbState;

  typedef enum logic {
    SRC_IMEM = 1'b0,
    SRC_DMEM = 1'b1
  } MemSource;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order tag FIFO: one bit per in-flight downstream request recording the
// source port, so responses can be steered back in issue order.
//   clk, reset : clock, async active-high reset (clears pointers and count)
//   i_push     : write i_din (ignored when full)
//   i_pop      : drop head entry (ignored when empty)
//   o_dout     : head entry
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
module mem_arb_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_din,
  output logic o_dout,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_dout  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) round-robin arbiter onto one downstream memory port.
// Requests pass through combinationally; a tag FIFO steers in-order responses
// back to the issuing port. M_FLUSH_ALL is serialised: outstanding traffic is
// drained first, then the flush goes out alone and blocks grants until its
// response returns.
//   clk, reset          : clock, async active-high reset
//   imem_in / imem_out  : fetch requester
//   dmem_in / dmem_out  : data requester
//   mem_req / mem_rsp   : shared downstream port
//   err_unexpected_rsp  : sticky, response seen with nothing in flight
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  MemoryIn  imem_in,
  output MemoryOut imem_out,
  input  MemoryIn  dmem_in,
  output MemoryOut dmem_out,
  output MemoryIn  mem_req,
  input  MemoryOut mem_rsp,
  output logic     err_unexpected_rsp
);

  ArbState  r_state;
  logic     r_lock;
  MemSource r_lock_src;
  MemSource r_last;
  logic     r_err;

  MemSource w_gnt;
  MemoryIn  w_sel;
  logic     w_flush;
  logic     w_open;
  logic     w_mem_vld;
  logic     w_push;
  logic     w_pop;
  logic     w_full;
  logic     w_empty;
  logic     w_head;

  // Grant: a stalled or drain-parked request keeps the port; otherwise
  // alternate on contention, else whoever is valid.
  always_comb begin
    w_gnt = SRC_IMEM;
    if (r_lock)
      w_gnt = r_lock_src;
    else if (imem_in.req_valid && dmem_in.req_valid)
      w_gnt = (r_last == SRC_IMEM) ? SRC_DMEM : SRC_IMEM;
    else if (dmem_in.req_valid)
      w_gnt = SRC_DMEM;
  end

  assign w_sel   = (w_gnt == SRC_DMEM) ? dmem_in : imem_in;
  assign w_flush = w_sel.req_valid && (w_sel.req.fcn == M_FLUSH_ALL);

  // Downstream is open only in RUN, with tag room, and never for a flush
  // while anything is still outstanding.
  assign w_open    = !reset && (r_state == RUN) && !w_full && !(w_flush && !w_empty);
  assign w_mem_vld = w_sel.req_valid && w_open;
  assign w_push    = w_mem_vld && mem_rsp.req_ready;
  assign w_pop     = !reset && mem_rsp.res_valid && !w_empty;

  assign mem_req.req       = w_sel.req;
  assign mem_req.req_valid = w_mem_vld;

  assign imem_out.res       = mem_rsp.res;
  assign imem_out.req_ready = (w_gnt == SRC_IMEM) && mem_rsp.req_ready && w_open;
  assign imem_out.res_valid = w_pop && (w_head == SRC_IMEM);

  assign dmem_out.res       = mem_rsp.res;
  assign dmem_out.req_ready = (w_gnt == SRC_DMEM) && mem_rsp.req_ready && w_open;
  assign dmem_out.res_valid = w_pop && (w_head == SRC_DMEM);

  assign err_unexpected_rsp = r_err;

  mem_arb_tag_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_gnt),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_lock     <= 1'b0;
      r_lock_src <= SRC_IMEM;
      r_last     <= SRC_IMEM;
      r_err      <= 1'b0;
    end else begin
      if (mem_rsp.res_valid && w_empty) r_err <= 1'b1;
      if (w_push) r_last <= w_gnt;
      case (r_state)
        RUN: begin
          if (w_flush && !w_empty) begin
            // Park the flush's port so it is re-granted once drained.
            r_state    <= DRAIN;
            r_lock     <= 1'b1;
            r_lock_src <= w_gnt;
          end else begin
            r_lock     <= w_mem_vld && !mem_rsp.req_ready;
            r_lock_src <= w_gnt;
            if (w_push && w_flush) r_state <= FLUSH;
          end
        end
        DRAIN:   if (w_empty) r_state <= RUN;
        // The flush tag is the only one outstanding, so any pop is its response.
        FLUSH:   if (w_pop) r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int OUT = 4;

  logic     clk = 1'b0;
  logic     reset;
  MemoryIn  imem_in, dmem_in, mem_req;
  MemoryOut imem_out, dmem_out, mem_rsp;
  logic     err;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.OUTSTANDING(OUT)) dut (
    .clk                (clk),
    .reset              (reset),
    .imem_in            (imem_in),
    .imem_out           (imem_out),
    .dmem_in            (dmem_in),
    .dmem_out           (dmem_out),
    .mem_req            (mem_req),
    .mem_rsp            (mem_rsp),
    .err_unexpected_rsp (err)
  );

  always #5 clk = ~clk;

  function automatic MemoryReq rand_req(input logic flush);
    MemoryReq r;
    r.addr = $urandom;
    r.data = $urandom;
    r.typ  = 3'($urandom_range(0, 7));
    if (flush) r.fcn = M_FLUSH_ALL;
    else       r.fcn = ($urandom_range(0, 1) == 1) ? M_XWR : M_XRD;
    return r;
  endfunction

  task automatic idle();
    imem_in = '0;
    dmem_in = '0;
    mem_rsp = '0;
  endtask

  // Drive window begins 1 time unit after a rising edge; checks happen 2 later.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    imem_in.req = rand_req(0); imem_in.req_valid = 1'b1;
    dmem_in.req = rand_req(0); dmem_in.req_valid = 1'b1;
    mem_rsp.req_ready = 1'b1; mem_rsp.res_valid = 1'b1; mem_rsp.res.data = $urandom;
    reset = 1'b1;
    #2;
    checks++;
    if ({imem_out.req_ready, imem_out.res_valid, dmem_out.req_ready, dmem_out.res_valid,
         mem_req.req_valid, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 000000", {imem_out.req_ready, imem_out.res_valid,
               dmem_out.req_ready, dmem_out.res_valid, mem_req.req_valid, err});
    end
    do_reset();
    #2;
    checks++;
    if ({mem_req.req_valid, err, imem_out.res_valid, dmem_out.res_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle got %b exp 0000",
               {mem_req.req_valid, err, imem_out.res_valid, dmem_out.res_valid});
    end
    next_cyc();
  endtask

  task automatic test_contention();
    MemSource q[$];
    MemSource exp, src;
    MemoryReq ireq, dreq, ereq;
    logic [31:0] d;
    do_reset();
    ireq = rand_req(0); dreq = rand_req(0);
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      imem_in.req = ireq; imem_in.req_valid = 1'b1;
      dmem_in.req = dreq; dmem_in.req_valid = 1'b1;
      mem_rsp.req_ready = 1'b1;
      mem_rsp.res_valid = (q.size() > 0);
      mem_rsp.res.data  = d;
      #2;
      exp  = (i % 2 == 0) ? SRC_DMEM : SRC_IMEM;
      ereq = (exp == SRC_DMEM) ? dreq : ireq;
      checks++;
      if (mem_req.req_valid !== 1'b1 || mem_req.req !== ereq) begin
        errors++;
        $display("FAIL contention_req cyc %0d got v=%b %h exp v=1 %h", i, mem_req.req_valid, mem_req.req, ereq);
      end
      checks++;
      if ({imem_out.req_ready, dmem_out.req_ready} !== ((exp == SRC_DMEM) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL contention_ready cyc %0d got %b exp src %0d", i,
                 {imem_out.req_ready, dmem_out.req_ready}, exp);
      end
      if (q.size() > 0) begin
        src = q.pop_front();
        checks++;
        if ({imem_out.res_valid, dmem_out.res_valid} !== ((src == SRC_DMEM) ? 2'b01 : 2'b10) ||
            ((src == SRC_DMEM) ? dmem_out.res.data : imem_out.res.data) !== d) begin
          errors++;
          $display("FAIL contention_rsp cyc %0d got %b exp src %0d data %h", i,
                   {imem_out.res_valid, dmem_out.res_valid}, src, d);
        end
      end
      q.push_back(exp);
      if (exp == SRC_DMEM) dreq = rand_req(0); else ireq = rand_req(0);
      next_cyc();
    end
    idle();
  endtask

  task automatic test_stall_lock();
    MemoryReq ireq, dreq;
    do_reset();
    ireq = rand_req(0); dreq = rand_req(0);
    imem_in.req = ireq; imem_in.req_valid = 1'b1;
    dmem_in.req = dreq; dmem_in.req_valid = 1'b1;
    mem_rsp.req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (mem_req.req_valid !== 1'b1 || mem_req.req !== dreq ||
          {imem_out.req_ready, dmem_out.req_ready} !== 2'b00) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got v=%b %h rdy=%b exp v=1 %h rdy=00", i,
                 mem_req.req_valid, mem_req.req, {imem_out.req_ready, dmem_out.req_ready}, dreq);
      end
      next_cyc();
    end
    mem_rsp.req_ready = 1'b1;
    #2;
    checks++;
    if (mem_req.req !== dreq || {imem_out.req_ready, dmem_out.req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL stall_release got %h rdy=%b exp %h rdy=01", mem_req.req,
               {imem_out.req_ready, dmem_out.req_ready}, dreq);
    end
    next_cyc();
    dmem_in.req_valid = 1'b0;
    #2;
    checks++;
    if (mem_req.req_valid !== 1'b1 || mem_req.req !== ireq || imem_out.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_then_imem got v=%b %h rdy=%b exp v=1 %h rdy=1", mem_req.req_valid,
               mem_req.req, imem_out.req_ready, ireq);
    end
    next_cyc();
    // imem stalls alone; dmem arriving later would win the tie but must not steal.
    ireq = rand_req(0); dreq = rand_req(0);
    imem_in.req = ireq; imem_in.req_valid = 1'b1;
    mem_rsp.req_ready = 1'b0;
    next_cyc();
    dmem_in.req = dreq; dmem_in.req_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (mem_req.req !== ireq || mem_req.req_valid !== 1'b1) begin
        errors++;
        $display("FAIL lock_no_steal cyc %0d got %h exp %h", i, mem_req.req, ireq);
      end
      next_cyc();
    end
    mem_rsp.req_ready = 1'b1;
    #2;
    checks++;
    if (imem_out.req_ready !== 1'b1 || dmem_out.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL lock_accept got rdy=%b exp 10", {imem_out.req_ready, dmem_out.req_ready});
    end
    next_cyc();
    idle();
  endtask

  task automatic test_full_fifo();
    MemoryReq ireq;
    logic [31:0] d;
    do_reset();
    imem_in.req_valid = 1'b1;
    mem_rsp.req_ready = 1'b1;
    for (int i = 0; i < OUT; i++) begin
      ireq = rand_req(0); imem_in.req = ireq;
      #2;
      checks++;
      if (imem_out.req_ready !== 1'b1 || mem_req.req_valid !== 1'b1) begin
        errors++;
        $display("FAIL full_fill cyc %0d got rdy=%b v=%b exp 1 1", i, imem_out.req_ready, mem_req.req_valid);
      end
      next_cyc();
    end
    ireq = rand_req(0); imem_in.req = ireq;
    #2;
    checks++;
    if (imem_out.req_ready !== 1'b0 || mem_req.req_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_block got rdy=%b v=%b exp 0 0", imem_out.req_ready, mem_req.req_valid);
    end
    next_cyc();
    d = $urandom;
    mem_rsp.res_valid = 1'b1; mem_rsp.res.data = d;
    #2;
    checks++;
    if (imem_out.res_valid !== 1'b1 || dmem_out.res_valid !== 1'b0 || imem_out.res.data !== d) begin
      errors++;
      $display("FAIL full_rsp got v=%b%b %h exp v=10 %h", imem_out.res_valid, dmem_out.res_valid,
               imem_out.res.data, d);
    end
    checks++;
    if (imem_out.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_no_push_on_pop got rdy=%b exp 0", imem_out.req_ready);
    end
    next_cyc();
    mem_rsp.res_valid = 1'b0;
    #2;
    checks++;
    if (imem_out.req_ready !== 1'b1 || mem_req.req_valid !== 1'b1 || mem_req.req !== ireq) begin
      errors++;
      $display("FAIL full_fifth got rdy=%b v=%b %h exp 1 1 %h", imem_out.req_ready,
               mem_req.req_valid, mem_req.req, ireq);
    end
    next_cyc();
    idle();
  endtask

  task automatic test_flush();
    MemoryReq fr, dreq;
    logic [31:0] d;
    logic got;
    do_reset();
    dmem_in.req_valid = 1'b1;
    mem_rsp.req_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dmem_in.req = rand_req(0); dmem_in.req.fcn = M_XRD;
      #2;
      checks++;
      if (dmem_out.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL flush_loads cyc %0d got rdy=%b exp 1", i, dmem_out.req_ready);
      end
      next_cyc();
    end
    fr = rand_req(1); dreq = rand_req(0);
    imem_in.req = fr;   imem_in.req_valid = 1'b1;
    dmem_in.req = dreq; dmem_in.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if ({mem_req.req_valid, imem_out.req_ready, dmem_out.req_ready} !== 3'b000) begin
        errors++;
        $display("FAIL drain_no_grant cyc %0d got %b exp 000", i,
                 {mem_req.req_valid, imem_out.req_ready, dmem_out.req_ready});
      end
      next_cyc();
    end
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      mem_rsp.res_valid = 1'b1; mem_rsp.res.data = d;
      #2;
      checks++;
      if ({imem_out.res_valid, dmem_out.res_valid} !== 2'b01 || dmem_out.res.data !== d ||
          mem_req.req_valid !== 1'b0) begin
        errors++;
        $display("FAIL drain_rsp cyc %0d got rv=%b %h mv=%b exp rv=01 %h mv=0", i,
                 {imem_out.res_valid, dmem_out.res_valid}, dmem_out.res.data, mem_req.req_valid, d);
      end
      next_cyc();
    end
    mem_rsp.res_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      #2;
      if (mem_req.req_valid === 1'b1) begin
        got = 1'b1;
        checks++;
        if (mem_req.req !== fr || imem_out.req_ready !== 1'b1 || dmem_out.req_ready !== 1'b0) begin
          errors++;
          $display("FAIL flush_issue got %h rdy=%b exp %h rdy=10", mem_req.req,
                   {imem_out.req_ready, dmem_out.req_ready}, fr);
        end
      end
      next_cyc();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL flush_issue_timeout got none exp flush within 6 cycles");
    end
    imem_in.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if ({mem_req.req_valid, dmem_out.req_ready} !== 2'b00) begin
        errors++;
        $display("FAIL flush_block cyc %0d got %b exp 00", i, {mem_req.req_valid, dmem_out.req_ready});
      end
      next_cyc();
    end
    d = $urandom;
    mem_rsp.res_valid = 1'b1; mem_rsp.res.data = d;
    #2;
    checks++;
    if ({imem_out.res_valid, dmem_out.res_valid} !== 2'b10 || imem_out.res.data !== d) begin
      errors++;
      $display("FAIL flush_rsp got %b %h exp 10 %h", {imem_out.res_valid, dmem_out.res_valid},
               imem_out.res.data, d);
    end
    next_cyc();
    mem_rsp.res_valid = 1'b0;
    #2;
    checks++;
    if (mem_req.req_valid !== 1'b1 || mem_req.req !== dreq || dmem_out.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_resume got v=%b %h exp v=1 %h", mem_req.req_valid, mem_req.req, dreq);
    end
    next_cyc();
    idle();
  endtask

  task automatic test_unexpected();
    do_reset();
    mem_rsp.res_valid = 1'b1; mem_rsp.res.data = $urandom;
    #2;
    checks++;
    if ({imem_out.res_valid, dmem_out.res_valid} !== 2'b00) begin
      errors++;
      $display("FAIL unexp_route got %b exp 00", {imem_out.res_valid, dmem_out.res_valid});
    end
    next_cyc();
    mem_rsp.res_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (err !== 1'b1) begin
        errors++;
        $display("FAIL unexp_sticky cyc %0d got %b exp 1", i, err);
      end
      next_cyc();
    end
    reset = 1'b1;
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL unexp_clear got %b exp 0", err);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_in.req_valid = 1'b1;
    mem_rsp.req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_in.req = rand_req(0);
      next_cyc();
    end
    dmem_in.req = rand_req(0); dmem_in.req_valid = 1'b1;
    mem_rsp.res_valid = 1'b1; mem_rsp.res.data = $urandom;
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({imem_out.req_ready, imem_out.res_valid, dmem_out.req_ready, dmem_out.res_valid,
         mem_req.req_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_async got %b exp 00000", {imem_out.req_ready, imem_out.res_valid,
               dmem_out.req_ready, dmem_out.res_valid, mem_req.req_valid});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    idle();
    mem_rsp.res_valid = 1'b1;
    #2;
    checks++;
    if ({imem_out.res_valid, dmem_out.res_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_tags_gone got %b exp 00", {imem_out.res_valid, dmem_out.res_valid});
    end
    next_cyc();
    mem_rsp.res_valid = 1'b0;
    #2;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL reset_count_zero got err=%b exp 1", err);
    end
    next_cyc();
  endtask

  // Random traffic against a queue model: requesters hold until accepted,
  // responses only while something is outstanding.
  task automatic test_random();
    MemSource q[$];
    MemSource last, g, src, stall_src;
    logic stalled, iv, dv, rdy, rv, gv, room, mv;
    MemoryReq ireq, dreq;
    logic [31:0] d;
    do_reset();
    last = SRC_IMEM; stalled = 1'b0; stall_src = SRC_IMEM;
    iv = 1'b0; dv = 1'b0; ireq = '0; dreq = '0;
    for (int c = 0; c < 400; c++) begin
      if (!iv && $urandom_range(0, 1) == 1) begin iv = 1'b1; ireq = rand_req(0); end
      if (!dv && $urandom_range(0, 1) == 1) begin dv = 1'b1; dreq = rand_req(0); end
      rdy = ($urandom_range(0, 3) != 0);
      rv  = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      d   = $urandom;
      imem_in.req = ireq; imem_in.req_valid = iv;
      dmem_in.req = dreq; dmem_in.req_valid = dv;
      mem_rsp.req_ready = rdy; mem_rsp.res_valid = rv; mem_rsp.res.data = d;
      #2;
      if (stalled)          g = stall_src;
      else if (iv && dv)    g = (last == SRC_IMEM) ? SRC_DMEM : SRC_IMEM;
      else if (dv)          g = SRC_DMEM;
      else                  g = SRC_IMEM;
      gv   = (g == SRC_DMEM) ? dv : iv;
      room = (q.size() < OUT);
      mv   = gv && room;
      checks++;
      if (mem_req.req_valid !== mv || (mv && mem_req.req !== ((g == SRC_DMEM) ? dreq : ireq))) begin
        errors++;
        $display("FAIL rand_req cyc %0d got v=%b %h exp v=%b src %0d", c, mem_req.req_valid,
                 mem_req.req, mv, g);
      end
      checks++;
      if ({imem_out.req_ready, dmem_out.req_ready} !==
          ((g == SRC_DMEM) ? {1'b0, rdy && room} : {rdy && room, 1'b0})) begin
        errors++;
        $display("FAIL rand_ready cyc %0d got %b exp src %0d rdy %b", c,
                 {imem_out.req_ready, dmem_out.req_ready}, g, rdy && room);
      end
      checks++;
      if (rv) begin
        src = q.pop_front();
        if ({imem_out.res_valid, dmem_out.res_valid} !== ((src == SRC_DMEM) ? 2'b01 : 2'b10) ||
            ((src == SRC_DMEM) ? dmem_out.res.data : imem_out.res.data) !== d) begin
          errors++;
          $display("FAIL rand_rsp cyc %0d got %b exp src %0d data %h", c,
                   {imem_out.res_valid, dmem_out.res_valid}, src, d);
        end
      end else if ({imem_out.res_valid, dmem_out.res_valid} !== 2'b00) begin
        errors++;
        $display("FAIL rand_rsp_idle cyc %0d got %b exp 00", c, {imem_out.res_valid, dmem_out.res_valid});
      end
      if (mv && rdy) begin
        q.push_back(g);
        last = g;
        if (g == SRC_DMEM) dv = 1'b0; else iv = 1'b0;
      end
      stalled   = mv && !rdy;
      stall_src = g;
      next_cyc();
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL rand_err got %b exp 0", err);
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_contention();
    test_stall_lock();
    test_full_fifo();
    test_flush();
    test_unexpected();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
